bios_program_loader: RTL and testbench
======================================

# bios_program_loader

Copies a program image of PROGRAM_LENGTH words from the BIOS/storage read port into instruction memory, then emits the change-state instruction (opcode 6'b100111) on the BIOS instruction path so the instruction source selector hands control to the loaded program. It is the producer side of the BIOS-to-program handover and sits between the BIOS ROM, the instruction RAM write port and the instruction source multiplexer. One-shot per reset, like the selector it feeds.

## Interface
- DATA_WIDTH, 32, instruction word width; opcode occupies bits [DATA_WIDTH-1:DATA_WIDTH-6]
- ADDR_WIDTH, 10, source and instruction-memory address width
- OPCODE_WIDTH, 6, opcode field width
- CLOCK  in  1  single clock, all state on posedge
- RESET_N  in  1  synchronous, active-low reset
- START  in  1  begin transfer; sampled only in IDLE
- PROGRAM_LENGTH  in  ADDR_WIDTH+1  words to copy; latched on accepted START
- SOURCE_ADDRESS  out  ADDR_WIDTH  registered read address to source ROM (1-cycle read latency)
- SOURCE_DATA  in  DATA_WIDTH  word for address presented in previous cycle
- IMEM_WRITE_ENABLE  out  1  instruction-memory write strobe
- IMEM_WRITE_ADDRESS  out  ADDR_WIDTH  instruction-memory write address
- IMEM_WRITE_DATA  out  DATA_WIDTH  instruction-memory write data (= SOURCE_DATA in COPY)
- HANDOVER_INSTRUCTION  out  DATA_WIDTH  {CHANGE_STATE_OPCODE, zeros} during HANDOVER, else 0
- HANDOVER_VALID  out  1  high exactly one cycle, in HANDOVER
- BUSY  out  1  high in FETCH, COPY, HANDOVER
- DONE  out  1  high in DONE state, sticky until reset

## Operation
- States: IDLE, FETCH, COPY, HANDOVER, DONE.
- IDLE: START=1 and PROGRAM_LENGTH≠0 → latch length (clamped to 2^ADDR_WIDTH), FETCH. START=1 and length=0 → HANDOVER directly.
- FETCH: SOURCE_ADDRESS=0; write counter=0 → COPY.
- COPY: IMEM_WRITE_ENABLE=1, IMEM_WRITE_ADDRESS=write counter, IMEM_WRITE_DATA=SOURCE_DATA; SOURCE_ADDRESS=write counter+1 (read-ahead). On write counter = length−1 → HANDOVER, else counter+1.
- HANDOVER: HANDOVER_VALID=1, HANDOVER_INSTRUCTION={6'b100111, 0} → DONE.
- DONE: DONE=1; START ignored; leaves only via reset.
- START while BUSY or DONE: ignored, no effect on counters or length.
- Outside FETCH/COPY: SOURCE_ADDRESS=0, IMEM_WRITE_ENABLE=0, write address/data=0.
- Read-ahead address on last COPY cycle may equal length (or wrap to 0 at full length); data unused.
- Counters ADDR_WIDTH+1 bits wide internally; no wrap of write address within a transfer.

## Timing
- Reset (RESET_N=0 at an edge): state IDLE; every output 0 after that edge. Reset mid-COPY aborts immediately; no further writes, no handover.
- START accepted at edge 0 → FETCH in cycle 1 → COPY cycles 2..N+1 (word k written in cycle k+2) → HANDOVER cycle N+2 → DONE from cycle N+3.
- Length 0: HANDOVER in cycle 1, DONE from cycle 2, no writes.
- Throughput 1 word/cycle; total N+2 cycles from START to handover.
- All outputs driven from registered state (state decode only, no input-to-output paths except IMEM_WRITE_DATA = SOURCE_DATA in COPY).

## Structure
- Shared package/include: OPCODE_WIDTH, CHANGE_STATE_OPCODE (6'b100111), BIOS_PROCESSING/IGNORE_BIOS state constants, loader state encodings — shared with instruction_source_selector so the opcode is defined once.
- One sub-module: transfer_address_counter (load/clear, increment, terminal-count compare against latched length).

## Test plan
- Reset then START with length 4, ROM[i]=0xA000_0000+i → writes addr 0..3 with 0xA000_0000..0xA000_0003 in cycles 2..5, HANDOVER_VALID cycle 6 with 0x9C00_0000, DONE from cycle 7.
- START with length 0 → no IMEM writes, HANDOVER_VALID in cycle 1, DONE cycle 2.
- START pulsed repeatedly during COPY and in DONE → write sequence and count unchanged, no second handover.
- RESET_N low in cycle 3 of a length-8 transfer → IMEM_WRITE_ENABLE 0 next cycle, BUSY/DONE 0, IDLE; new START restarts from address 0.
- Length 1024 (full, ADDR_WIDTH=10) → 1024 writes, last addr 1023, handover at cycle 1026; loader output into instruction_source_selector switches its selection to 1 on the edge after HANDOVER_VALID.

Source files
------------

// File: rtl/bios_program_loader_pkg.sv
// rtl/bios_program_loader_pkg.sv - opcode, selector and loader state constants shared across the BIOS handover path
package bios_program_loader_pkg;

    localparam int OPCODE_WIDTH = 6;
    localparam logic [OPCODE_WIDTH-1:0] CHANGE_STATE_OPCODE = 6'b100111;

    // instruction_source_selector selection values
    localparam logic BIOS_PROCESSING = 1'b0;
    localparam logic IGNORE_BIOS     = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_COPY,
        ST_HANDOVER,
        ST_DONE
    } loader_state_t;

endpackage

// File: rtl/bios_program_loader_transfer_address_counter.sv
// rtl/bios_program_loader_transfer_address_counter.sv - word counter with latched length and terminal-count compare
module transfer_address_counter #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  load,
    input  logic [ADDR_WIDTH:0]   length_in,
    input  logic                  clear,
    input  logic                  increment,
    output logic                  terminal,
    output logic [ADDR_WIDTH-1:0] write_address_next,
    output logic [ADDR_WIDTH-1:0] read_address_next
);

    localparam logic [ADDR_WIDTH:0] one = (ADDR_WIDTH+1)'(1);

    logic [ADDR_WIDTH:0] count;
    logic [ADDR_WIDTH:0] length_q;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            count    <= '0;
            length_q <= '0;
        end else begin
            if (load) begin
                length_q <= length_in;
            end
            if (clear) begin
                count <= '0;
            end else if (increment) begin
                count <= count + one;
            end
        end
    end

    assign terminal = (count == length_q - one);

    // read-ahead runs one word past the write address; wraps to 0 at full length
    assign write_address_next = count[ADDR_WIDTH-1:0] + ADDR_WIDTH'(1);
    assign read_address_next  = count[ADDR_WIDTH-1:0] + ADDR_WIDTH'(2);

endmodule

// File: rtl/bios_program_loader.sv
// rtl/bios_program_loader.sv - copies the BIOS program image into instruction memory, then issues the change-state instruction
module bios_program_loader #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 10,
    parameter int OPCODE_WIDTH = bios_program_loader_pkg::OPCODE_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   program_length,
    output logic [ADDR_WIDTH-1:0] source_address,
    input  logic [DATA_WIDTH-1:0] source_data,
    output logic                  imem_write_enable,
    output logic [ADDR_WIDTH-1:0] imem_write_address,
    output logic [DATA_WIDTH-1:0] imem_write_data,
    output logic [DATA_WIDTH-1:0] handover_instruction,
    output logic                  handover_valid,
    output logic                  busy,
    output logic                  done
);

    import bios_program_loader_pkg::*;

    localparam logic [ADDR_WIDTH:0] full_length = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [DATA_WIDTH-1:0] handover_word =
        {OPCODE_WIDTH'(CHANGE_STATE_OPCODE), {(DATA_WIDTH-OPCODE_WIDTH){1'b0}}};

    loader_state_t         state;
    logic [ADDR_WIDTH:0]   clamped_length;
    logic                  terminal;
    logic [ADDR_WIDTH-1:0] write_address_next;
    logic [ADDR_WIDTH-1:0] read_address_next;

    assign clamped_length = (program_length > full_length) ? full_length : program_length;

    transfer_address_counter #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_counter (
        .clock              (clock),
        .reset_n            (reset_n),
        .load               (state == ST_IDLE && start),
        .length_in          (clamped_length),
        .clear              (state == ST_FETCH),
        .increment          (state == ST_COPY && !terminal),
        .terminal           (terminal),
        .write_address_next (write_address_next),
        .read_address_next  (read_address_next)
    );

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state                <= ST_IDLE;
            source_address       <= '0;
            imem_write_enable    <= 1'b0;
            imem_write_address   <= '0;
            handover_instruction <= '0;
            handover_valid       <= 1'b0;
            busy                 <= 1'b0;
            done                 <= 1'b0;
        end else begin
            source_address       <= '0;
            imem_write_enable    <= 1'b0;
            imem_write_address   <= '0;
            handover_instruction <= '0;
            handover_valid       <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (program_length != '0) begin
                            state <= ST_FETCH;
                        end else begin
                            state                <= ST_HANDOVER;
                            handover_valid       <= 1'b1;
                            handover_instruction <= handover_word;
                        end
                    end
                end
                ST_FETCH: begin
                    state             <= ST_COPY;
                    imem_write_enable <= 1'b1;
                    source_address    <= ADDR_WIDTH'(1);
                end
                ST_COPY: begin
                    if (terminal) begin
                        state                <= ST_HANDOVER;
                        handover_valid       <= 1'b1;
                        handover_instruction <= handover_word;
                    end else begin
                        imem_write_enable  <= 1'b1;
                        imem_write_address <= write_address_next;
                        source_address     <= read_address_next;
                    end
                end
                ST_HANDOVER: begin
                    state <= ST_DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                ST_DONE: begin
                    done <= 1'b1;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // the only input-to-output path: ROM data streams straight through while copying
    assign imem_write_data = imem_write_enable ? source_data : '0;

endmodule

// File: tb/tb_bios_program_loader.sv
// tb/tb_bios_program_loader.sv - scoreboard bench for bios_program_loader with a ROM model and random images
module tb_bios_program_loader;

    localparam int DW = 32;
    localparam int AW = 10;
    localparam int ROM_WORDS = 1 << AW;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic [AW:0]   program_length = '0;
    logic [AW-1:0] source_address;
    logic [DW-1:0] source_data;
    logic          imem_write_enable;
    logic [AW-1:0] imem_write_address;
    logic [DW-1:0] imem_write_data;
    logic [DW-1:0] handover_instruction;
    logic          handover_valid;
    logic          busy;
    logic          done;

    typedef struct {
        bit            is_handover;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            cyc;
    } ev_t;

    ev_t           exp_q[$];
    logic [DW-1:0] rom [0:ROM_WORDS-1];
    int            cyc = 0;
    int            vectors = 0;
    int            miscompares = 0;

    bios_program_loader #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .OPCODE_WIDTH(6)
    ) dut (
        .clock                (clock),
        .reset_n              (reset_n),
        .start                (start),
        .program_length       (program_length),
        .source_address       (source_address),
        .source_data          (source_data),
        .imem_write_enable    (imem_write_enable),
        .imem_write_address   (imem_write_address),
        .imem_write_data      (imem_write_data),
        .handover_instruction (handover_instruction),
        .handover_valid       (handover_valid),
        .busy                 (busy),
        .done                 (done)
    );

    always #5 clock = ~clock;

    // synchronous ROM: data for the address presented in the previous cycle
    always @(posedge clock) begin
        cyc         <= cyc + 1;
        source_data <= rom[source_address];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clock) begin
        ev_t ex;
        if (imem_write_enable || handover_valid) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_output: we=%0b hv=%0b addr=%0h at cycle %0d, expected nothing",
                         imem_write_enable, handover_valid, imem_write_address, cyc);
            end else begin
                ex = exp_q.pop_front();
                check("event_kind", 64'(handover_valid), 64'(ex.is_handover));
                check("event_cycle", 64'(cyc), 64'(ex.cyc));
                if (ex.is_handover) begin
                    check("handover_instruction", 64'(handover_instruction), 64'(ex.data));
                end else begin
                    check("write_address", 64'(imem_write_address), 64'(ex.addr));
                    check("write_data", 64'(imem_write_data), 64'(ex.data));
                end
            end
        end
    end

    task automatic wait_cyc(input int target, input bit pulse);
        int guard = 0;
        while (cyc < target) begin
            @(negedge clock);
            if (pulse && cyc < target) begin
                start          = 1'($urandom_range(0, 1));
                program_length = (AW+1)'($urandom);
            end
            guard++;
            if (guard > 5000) begin
                vectors++;
                miscompares++;
                $display("FAIL wait_timeout: reached cycle %0d, required %0d", cyc, target);
                break;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset_n = 1'b0;
        start   = 1'b0;
        repeat (2) @(negedge clock);
        check("reset_source_address", 64'(source_address), 64'd0);
        check("reset_write_enable", 64'(imem_write_enable), 64'd0);
        check("reset_write_address", 64'(imem_write_address), 64'd0);
        check("reset_write_data", 64'(imem_write_data), 64'd0);
        check("reset_handover_instruction", 64'(handover_instruction), 64'd0);
        check("reset_handover_valid", 64'(handover_valid), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        exp_q.delete();
        reset_n = 1'b1;
    endtask

    // expected behaviour: N = min(len, 2^AW) words, word k in cycle k+2, handover in cycle N+2 (cycle 1 if N=0)
    task automatic issue_start(input int len, output int e, output int hand);
        int  n;
        ev_t ev;
        @(negedge clock);
        start          = 1'b1;
        program_length = len[AW:0];
        e = cyc + 1;
        n = (len > ROM_WORDS) ? ROM_WORDS : len;
        for (int k = 0; k < n; k++) begin
            ev.is_handover = 1'b0;
            ev.addr        = k[AW-1:0];
            ev.data        = rom[k];
            ev.cyc         = e + k + 1;
            exp_q.push_back(ev);
        end
        hand = (n == 0) ? e : e + n + 1;
        ev.is_handover = 1'b1;
        ev.addr        = '0;
        ev.data        = DW'(39) << (DW - 6);
        ev.cyc         = hand;
        exp_q.push_back(ev);
        @(negedge clock);
        start = 1'b0;
        check("first_cycle_busy", 64'(busy), 64'd1);
        if (n > 0) begin
            check("fetch_source_address", 64'(source_address), 64'd0);
            check("fetch_write_enable", 64'(imem_write_enable), 64'd0);
        end
    endtask

    task automatic finish_transfer(input int hand, input bit pulse);
        wait_cyc(hand + 1, pulse);
        start = 1'b0;
        check("done_after_handover", 64'(done), 64'd1);
        check("busy_after_handover", 64'(busy), 64'd0);
        repeat (8) begin
            @(negedge clock);
            start          = 1'($urandom_range(0, 1));
            program_length = (AW+1)'($urandom);
        end
        @(negedge clock);
        start = 1'b0;
        check("done_sticky", 64'(done), 64'd1);
        check("busy_in_done", 64'(busy), 64'd0);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic fill_rom_random();
        for (int i = 0; i < ROM_WORDS; i++) begin
            rom[i] = $urandom;
        end
    endtask

    initial begin
        int e;
        int hand;
        int len;

        for (int i = 0; i < ROM_WORDS; i++) begin
            rom[i] = 32'hA000_0000 + i;
        end

        do_reset();
        issue_start(4, e, hand);
        finish_transfer(hand, 1'b0);

        do_reset();
        issue_start(0, e, hand);
        finish_transfer(hand, 1'b0);

        fill_rom_random();
        do_reset();
        issue_start(12, e, hand);
        finish_transfer(hand, 1'b1);

        // reset in cycle 3 of a length-8 transfer aborts it; the next start begins at address 0
        do_reset();
        issue_start(8, e, hand);
        wait_cyc(e + 2, 1'b0);
        reset_n = 1'b0;
        @(negedge clock);
        check("abort_write_enable", 64'(imem_write_enable), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_handover_valid", 64'(handover_valid), 64'd0);
        exp_q.delete();
        reset_n = 1'b1;
        fill_rom_random();
        issue_start(6, e, hand);
        finish_transfer(hand, 1'b1);

        repeat (4) begin
            fill_rom_random();
            len = $urandom_range(1, 50);
            do_reset();
            issue_start(len, e, hand);
            finish_transfer(hand, 1'($urandom_range(0, 1)));
        end

        fill_rom_random();
        do_reset();
        issue_start(ROM_WORDS, e, hand);
        finish_transfer(hand, 1'b0);

        fill_rom_random();
        do_reset();
        issue_start(1500, e, hand);
        finish_transfer(hand, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
